y86_seq_ctrl: RTL and testbench

Multi-cycle sequencing and status controller for the Y86 SEQ core. It owns the program counter, steps each instruction through explicit fetch/decode/execute/memory/writeback/PC-update stages, and latches the architectural status code (AOK/HLT/ADR/INS) with fixed priority. It also keeps retired-instruction and active-cycle counters. It replaces free-running combinational PC feedback with a registered, resettable, parametrised control path in front of the existing stage units.

---
 rtl/y86_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_y86_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_ctrl.sv
// Y86 SEQ sequencing/status controller: PC register, stage FSM, status latch, counters.
// Optional single-step support is enabled with `define SINGLE_STEP_EN.
module y86_seq_ctrl #(
   parameter int unsigned       ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              hlt,
   input  logic              imem_err,
   input  logic              ins_err,
   input  logic              dmem_err,
`ifdef SINGLE_STEP_EN
   input  logic              step,
`endif
   output logic [ADDR_W-1:0] pc,
   output logic [3:0]        stage,
   output logic              running,
   output logic [1:0]        status,
   output logic [CNT_W-1:0]  retired,
   output logic [CNT_W-1:0]  cycles
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXECUTE   = 4'd3,
      S_MEMORY    = 4'd4,
      S_WRITEBACK = 4'd5,
      S_PCUPD     = 4'd6,
      S_STOP      = 4'd7
`ifdef SINGLE_STEP_EN
      , S_PAUSE   = 4'd8
`endif
   } state_t;

   typedef enum logic [1:0] {
      ST_AOK = 2'd0,
      ST_HLT = 2'd1,
      ST_ADR = 2'd2,
      ST_INS = 2'd3
   } status_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state, state_n;
   status_t           status_q, status_n;
   logic [ADDR_W-1:0] pc_n;
   logic              retire;
   logic              in_stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         status_q <= ST_AOK;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         status_q <= status_n;
      end
   end

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      status_n = status_q;
      retire   = 1'b0;
      case (state)
         S_IDLE:      if (start) state_n = S_FETCH;
         // Fetch-time faults in priority order; a halt retires, the others do not.
         S_FETCH: begin
            if (imem_err) begin
               state_n  = S_STOP;
               status_n = ST_ADR;
            end else if (ins_err) begin
               state_n  = S_STOP;
               status_n = ST_INS;
            end else if (hlt) begin
               state_n  = S_STOP;
               status_n = ST_HLT;
               retire   = 1'b1;
            end else begin
               state_n  = S_DECODE;
            end
         end
         S_DECODE:    state_n = S_EXECUTE;
         S_EXECUTE:   state_n = S_MEMORY;
         S_MEMORY: begin
            if (dmem_err) begin
               state_n  = S_STOP;
               status_n = ST_ADR;
            end else begin
               state_n  = S_WRITEBACK;
            end
         end
         S_WRITEBACK: state_n = S_PCUPD;
         S_PCUPD: begin
            pc_n   = new_pc;
            retire = 1'b1;
`ifdef SINGLE_STEP_EN
            state_n = S_PAUSE;
`else
            state_n = S_FETCH;
`endif
         end
         S_STOP:      state_n = S_STOP;
`ifdef SINGLE_STEP_EN
         S_PAUSE:     if (step) state_n = S_FETCH;
`endif
         default:     state_n = S_IDLE;
      endcase
   end

   assign in_stage = (state >= S_FETCH) && (state <= S_PCUPD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired <= '0;
         cycles  <= '0;
      end else begin
         if (retire && (retired != '1)) retired <= retired + CNT_ONE;
         if (in_stage && (cycles != '1)) cycles <= cycles + CNT_ONE;
      end
   end

   assign stage  = state;
   assign status = status_q;
`ifdef SINGLE_STEP_EN
   assign running = in_stage || (state == S_PAUSE);
`else
   assign running = in_stage;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Scoreboard bench for y86_seq_ctrl; narrow counters make saturation reachable.
// Covers the SINGLE_STEP_EN build when that macro is defined.
module tb_y86_seq_ctrl;

   localparam logic [15:0] RST_PC = 16'h0100;

   typedef struct packed {
      logic [3:0]  stage;
      logic        running;
      logic [15:0] pc;
      logic [1:0]  status;
      logic [3:0]  retired;
      logic [3:0]  cycles;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] new_pc = '0;
   logic        hlt = 1'b0, imem_err = 1'b0, ins_err = 1'b0, dmem_err = 1'b0;
`ifdef SINGLE_STEP_EN
   logic        step = 1'b0;
`endif
   logic [15:0] pc;
   logic [3:0]  stage;
   logic        running;
   logic [1:0]  status;
   logic [3:0]  retired, cycles;

   int unsigned checks = 0;
   int unsigned failures = 0;
   obs_t        sb[$];
   obs_t        e, o;
   logic [15:0] m_pc;
   logic [3:0]  m_ret, m_cyc;

   y86_seq_ctrl #(.ADDR_W(16), .RESET_PC(RST_PC), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .new_pc(new_pc),
      .hlt(hlt), .imem_err(imem_err), .ins_err(ins_err), .dmem_err(dmem_err),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .pc(pc), .stage(stage), .running(running), .status(status),
      .retired(retired), .cycles(cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] sat(input logic [3:0] x);
      return (x == 4'hF) ? x : x + 4'd1;
   endfunction

   task automatic push(input logic [3:0] st, input logic [1:0] sts);
      obs_t x;
      x.stage   = st;
      x.running = ((st >= 4'd1) && (st <= 4'd6)) || (st == 4'd8);
      x.pc      = m_pc;
      x.status  = sts;
      x.retired = m_ret;
      x.cycles  = m_cyc;
      sb.push_back(x);
   endtask

   task automatic clear_inputs();
      start = 0; hlt = 0; imem_err = 0; ins_err = 0; dmem_err = 0;
`ifdef SINGLE_STEP_EN
      step = 0;
`endif
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      m_pc = RST_PC; m_ret = '0; m_cyc = '0;
      #2 rst_n = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      @(posedge clk); #3;
      rst_n = 0;
      m_pc = RST_PC; m_ret = '0; m_cyc = '0;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) rst_n = 1;
         push(4'd0, 2'd0);
         if (c == 0) #1; else begin @(posedge clk); #1; end
         e = sb.pop_front();
         o = {stage, running, pc, status, retired, cycles};
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL reset c=%0d: got %h required %h", c, o, e);
         end
      end
   endtask

   // Clean instruction followed by a halting one; stimulus pulses afterwards are ignored.
   task automatic test_normal_and_halt();
      do_reset();
      for (int c = 0; c < 12; c++) begin
         clear_inputs();
         new_pc = 16'h000A;
         if (c == 0) begin
            start = 1; push(4'd1, 2'd0);
         end else if (c <= 6) begin
            m_cyc = sat(m_cyc);
            if (c == 6) begin m_pc = 16'h000A; m_ret = sat(m_ret); end
            push((c == 6) ? 4'd1 : 4'(c + 1), 2'd0);
         end else if (c == 7) begin
            hlt = 1; m_cyc = sat(m_cyc); m_ret = sat(m_ret);
            push(4'd7, 2'd1);
         end else begin
            start = 1; imem_err = 1; ins_err = 1; dmem_err = 1; new_pc = 16'h5555;
            push(4'd7, 2'd1);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         o = {stage, running, pc, status, retired, cycles};
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL normal_halt c=%0d: got %h required %h", c, o, e);
         end
      end
   endtask

   task automatic test_dmem_err();
      do_reset();
      for (int c = 0; c < 7; c++) begin
         clear_inputs();
         new_pc = 16'h0777;
         case (c)
            0: begin start = 1; dmem_err = 1; push(4'd1, 2'd0); end
            1: begin dmem_err = 1; m_cyc = sat(m_cyc); push(4'd2, 2'd0); end
            2, 3: begin m_cyc = sat(m_cyc); push(4'(c + 1), 2'd0); end
            4: begin dmem_err = 1; m_cyc = sat(m_cyc); push(4'd7, 2'd2); end
            default: begin start = 1; hlt = 1; push(4'd7, 2'd2); end
         endcase
         @(posedge clk); #1;
         e = sb.pop_front();
         o = {stage, running, pc, status, retired, cycles};
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL dmem_err c=%0d: got %h required %h", c, o, e);
         end
      end
   endtask

   task automatic test_fetch_priority();
      logic [2:0] errs [4] = '{3'b111, 3'b011, 3'b001, 3'b100};
      logic [1:0] want [4] = '{2'd2, 2'd3, 2'd1, 2'd2};
      for (int k = 0; k < 4; k++) begin
         do_reset();
         for (int c = 0; c < 2; c++) begin
            clear_inputs();
            if (c == 0) begin
               start = 1; push(4'd1, 2'd0);
            end else begin
               {imem_err, ins_err, hlt} = errs[k];
               m_cyc = sat(m_cyc);
               if (errs[k] == 3'b001) m_ret = sat(m_ret);
               push(4'd7, want[k]);
            end
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {stage, running, pc, status, retired, cycles};
            checks++;
            if (o !== e) begin
               failures++;
               $display("FAIL fetch_prio k=%0d c=%0d: got %h required %h", k, c, o, e);
            end
         end
      end
   endtask

   // 16 back-to-back instructions with start held and every error asserted outside its stage.
   task automatic test_back_to_back();
      do_reset();
      for (int c = 0; c <= 96; c++) begin
         int k;
         k = (c == 0) ? 0 : ((c - 1) % 6) + 1;
         start = 1;
         hlt = (k > 1); imem_err = (k > 1); ins_err = (k > 1);
         dmem_err = (k != 4);
         new_pc = 16'($urandom);
         if (c == 0) begin
            hlt = 0; imem_err = 0; ins_err = 0;
            push(4'd1, 2'd0);
         end else begin
            m_cyc = sat(m_cyc);
            if (k == 6) begin m_pc = new_pc; m_ret = sat(m_ret); end
            push((k == 6) ? 4'd1 : 4'(k + 1), 2'd0);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         o = {stage, running, pc, status, retired, cycles};
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL back_to_back c=%0d: got %h required %h", c, o, e);
         end
      end
      clear_inputs();
   endtask

   task automatic test_async_mid();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         clear_inputs();
         new_pc = 16'h0040;
         if (c == 0) begin
            start = 1; push(4'd1, 2'd0);
         end else if (c <= 8) begin
            m_cyc = sat(m_cyc);
            if (c == 6) begin m_pc = 16'h0040; m_ret = sat(m_ret); end
            push((c == 6) ? 4'd1 : ((c > 6) ? 4'(c - 5) : 4'(c + 1)), 2'd0);
         end else begin
            m_pc = RST_PC; m_ret = '0; m_cyc = '0;
            push(4'd0, 2'd0);
         end
         if (c == 9) begin #3 rst_n = 0; #1; end
         else begin @(posedge clk); #1; end
         e = sb.pop_front();
         o = {stage, running, pc, status, retired, cycles};
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL async_mid c=%0d: got %h required %h", c, o, e);
         end
      end
      #1 rst_n = 1;
   endtask

`ifdef SINGLE_STEP_EN
   task automatic test_step();
      do_reset();
      for (int c = 0; c < 14; c++) begin
         clear_inputs();
         new_pc = 16'h0123;
         if (c == 0) begin
            start = 1; step = 1; push(4'd1, 2'd0);
         end else if (c <= 6) begin
            m_cyc = sat(m_cyc);
            if (c == 6) begin m_pc = 16'h0123; m_ret = sat(m_ret); end
            push((c == 6) ? 4'd8 : 4'(c + 1), 2'd0);
         end else if (c <= 11) begin
            start = 1; push(4'd8, 2'd0);
         end else if (c == 12) begin
            step = 1; push(4'd1, 2'd0);
         end else begin
            m_cyc = sat(m_cyc); push(4'd2, 2'd0);
         end
         @(posedge clk); #1;
         e = sb.pop_front();
         o = {stage, running, pc, status, retired, cycles};
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL step c=%0d: got %h required %h", c, o, e);
         end
      end
   endtask
`endif

   initial begin
      m_pc = RST_PC; m_ret = '0; m_cyc = '0;
      test_reset();
      test_normal_and_halt();
      test_dmem_err();
      test_fetch_priority();
      test_back_to_back();
      test_async_mid();
`ifdef SINGLE_STEP_EN
      test_step();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
